// File: rtl/chess_clock_timer_pkg.sv
// Shared FSM state type, mm:ss field constants and a packing helper for the chess clock.
package chess_clock_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RUN_W,
      ST_RUN_B,
      ST_PAUSED,
      ST_TIMEOUT
   } state_e;

   localparam int unsigned MAX_MIN = 5;
   localparam int unsigned MAX_SEC = 59;
   localparam int unsigned MIN_MSB = 8;
   localparam int unsigned MIN_LSB = 6;
   localparam int unsigned SEC_MSB = 5;

   // Display word {1'b0, min[2:0], sec[5:0]}; bit 9 is always zero.
   function automatic logic [9:0] pack_mmss(input logic [2:0] m, input logic [5:0] s);
      logic [9:0] v;
      v = '0;
      v[MIN_MSB:MIN_LSB] = m;
      v[SEC_MSB:0] = s;
      return v;
   endfunction

endpackage

// File: rtl/chess_clock_timer_if.sv
// Bundle between the debounced button logic (master) and the countdown engine (slave).
interface chess_clock_timer_if;
   import chess_clock_pkg::*;

   // Control inputs are debounced levels; the slave edge-detects them. All slave
   // outputs are registered and valid every cycle, so there is no valid/ready pair.
   logic       start;
   logic       press_w;
   logic       press_b;
   logic       pause;
   logic       new_game;
   logic [9:0] countdownW;
   logic [9:0] countdownB;
   logic       turn_b;
   logic       running;
   logic       flag_w;
   logic       flag_b;
   state_e     dbg_state;

   modport master (
      output start, press_w, press_b, pause, new_game,
      input  countdownW, countdownB, turn_b, running, flag_w, flag_b, dbg_state
   );

   modport slave (
      input  start, press_w, press_b, pause, new_game,
      output countdownW, countdownB, turn_b, running, flag_w, flag_b, dbg_state
   );

endinterface

// File: rtl/chess_clock_timer_mmss_bank.sv
// One player's mm:ss time bank: borrow-style decrement, then saturating Fischer increment.
module mmss_bank
   import chess_clock_pkg::*;
#(
   parameter int unsigned INIT_MIN = 5,
   parameter int unsigned INIT_SEC = 0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic       dec_i,
   input  logic       inc_en_i,
   input  logic [5:0] inc_i,
   output logic [9:0] value_o,
   output logic       zero_next_o
);

   localparam logic [2:0] INIT_M = 3'(INIT_MIN);
   localparam logic [5:0] INIT_S = 6'(INIT_SEC);

   logic [2:0] min_q, min_d, dmin;
   logic [5:0] sec_q, sec_d, dsec;
   logic [6:0] sum;
   logic [3:0] min_inc;

   always_comb begin
      dmin = min_q;
      dsec = sec_q;
      if (dec_i) begin
         if (sec_q != 6'd0) begin
            dsec = sec_q - 6'd1;
         end else if (min_q != 3'd0) begin
            dmin = min_q - 3'd1;
            dsec = 6'(MAX_SEC);
         end
      end

      // Increment is applied on top of this cycle's decrement result.
      sum     = {1'b0, dsec} + {1'b0, inc_i};
      min_inc = {1'b0, dmin} + 4'd1;
      min_d   = dmin;
      sec_d   = dsec;

      if (load_i) begin
         min_d = INIT_M;
         sec_d = INIT_S;
      end else if (inc_en_i) begin
         if (sum > 7'(MAX_SEC)) begin
            if (min_inc > 4'(MAX_MIN)) begin
               min_d = 3'(MAX_MIN);
               sec_d = 6'(MAX_SEC);
            end else begin
               min_d = min_inc[2:0];
               sec_d = 6'(sum - 7'd60);
            end
         end else begin
            sec_d = sum[5:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q <= INIT_M;
         sec_q <= INIT_S;
      end else begin
         min_q <= min_d;
         sec_q <= sec_d;
      end
   end

   assign value_o     = pack_mmss(min_q, sec_q);
   // A decrement from here lands on 0:00.
   assign zero_next_o = (min_q == 3'd0) && (sec_q <= 6'd1);

endmodule

// File: rtl/chess_clock_timer.sv
// Two-player chess clock engine: 1 Hz prescaler, turn/pause/timeout FSM and two mm:ss banks.
module chess_clock_timer
   import chess_clock_pkg::*;
#(
   parameter int unsigned CLK_HZ   = 100_000_000,
   parameter int unsigned INIT_MIN = 5,
   parameter int unsigned INIT_SEC = 0,
   parameter int unsigned INC_SEC  = 0
) (
   input logic                clk,
   input logic                rst_n,
   chess_clock_timer_if.slave bus
);

   localparam int unsigned    PW         = $clog2(CLK_HZ);
   localparam logic [PW-1:0]  PRESC_LAST = PW'(CLK_HZ - 1);
   localparam logic [5:0]     INC_VAL    = 6'(INC_SEC);

   logic start_q, press_w_q, press_b_q, pause_q, new_game_q;
   logic start_e, press_w_e, press_b_e, pause_e, new_game_e;

   state_e        state_q;
   logic [PW-1:0] presc_q;
   logic          paused_b_q;
   logic          turn_b_q, running_q, flag_w_q, flag_b_q;

   logic          wrap, load;
   logic          dec_w, dec_b, inc_w, inc_b;
   logic          timeout_w, timeout_b, switch_w, switch_b;
   logic [9:0]    w_val, b_val;
   logic          w_zero_next, b_zero_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q    <= 1'b0;
         press_w_q  <= 1'b0;
         press_b_q  <= 1'b0;
         pause_q    <= 1'b0;
         new_game_q <= 1'b0;
      end else begin
         start_q    <= bus.start;
         press_w_q  <= bus.press_w;
         press_b_q  <= bus.press_b;
         pause_q    <= bus.pause;
         new_game_q <= bus.new_game;
      end
   end

   assign start_e    = bus.start    & ~start_q;
   assign press_w_e  = bus.press_w  & ~press_w_q;
   assign press_b_e  = bus.press_b  & ~press_b_q;
   assign pause_e    = bus.pause    & ~pause_q;
   assign new_game_e = bus.new_game & ~new_game_q;

   // Bank controls. A pause edge freezes the running side for that cycle, so
   // neither a tick nor a press is taken alongside it.
   always_comb begin
      wrap      = (presc_q == PRESC_LAST);
      load      = new_game_e;
      dec_w     = 1'b0;
      dec_b     = 1'b0;
      timeout_w = 1'b0;
      timeout_b = 1'b0;
      switch_w  = 1'b0;
      switch_b  = 1'b0;
      if (!new_game_e && !pause_e) begin
         if (state_q == ST_RUN_W) begin
            dec_w     = wrap;
            timeout_w = wrap && w_zero_next;
            switch_w  = press_w_e && !timeout_w;
         end
         if (state_q == ST_RUN_B) begin
            dec_b     = wrap;
            timeout_b = wrap && b_zero_next;
            switch_b  = press_b_e && !timeout_b;
         end
      end
      inc_w = switch_w;
      inc_b = switch_b;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         paused_b_q <= 1'b0;
         turn_b_q   <= 1'b0;
         running_q  <= 1'b0;
         flag_w_q   <= 1'b0;
         flag_b_q   <= 1'b0;
      end else if (new_game_e) begin
         state_q    <= ST_IDLE;
         presc_q    <= '0;
         paused_b_q <= 1'b0;
         turn_b_q   <= 1'b0;
         running_q  <= 1'b0;
         flag_w_q   <= 1'b0;
         flag_b_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_e) begin
                  state_q   <= ST_RUN_W;
                  presc_q   <= '0;
                  running_q <= 1'b1;
               end
            end
            ST_RUN_W, ST_RUN_B: begin
               if (pause_e) begin
                  state_q    <= ST_PAUSED;
                  paused_b_q <= (state_q == ST_RUN_B);
                  running_q  <= 1'b0;
               end else if (timeout_w || timeout_b) begin
                  state_q   <= ST_TIMEOUT;
                  running_q <= 1'b0;
                  flag_w_q  <= timeout_w;
                  flag_b_q  <= timeout_b;
               end else if (switch_w) begin
                  state_q  <= ST_RUN_B;
                  presc_q  <= '0;
                  turn_b_q <= 1'b1;
               end else if (switch_b) begin
                  state_q  <= ST_RUN_W;
                  presc_q  <= '0;
                  turn_b_q <= 1'b0;
               end else begin
                  presc_q <= wrap ? '0 : presc_q + PW'(1);
               end
            end
            ST_PAUSED: begin
               if (pause_e) begin
                  state_q   <= paused_b_q ? ST_RUN_B : ST_RUN_W;
                  running_q <= 1'b1;
               end
            end
            ST_TIMEOUT: begin
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   mmss_bank #(
      .INIT_MIN(INIT_MIN),
      .INIT_SEC(INIT_SEC)
   ) u_bank_w (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .dec_i      (dec_w),
      .inc_en_i   (inc_w),
      .inc_i      (INC_VAL),
      .value_o    (w_val),
      .zero_next_o(w_zero_next)
   );

   mmss_bank #(
      .INIT_MIN(INIT_MIN),
      .INIT_SEC(INIT_SEC)
   ) u_bank_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (load),
      .dec_i      (dec_b),
      .inc_en_i   (inc_b),
      .inc_i      (INC_VAL),
      .value_o    (b_val),
      .zero_next_o(b_zero_next)
   );

   assign bus.countdownW = w_val;
   assign bus.countdownB = b_val;
   assign bus.turn_b     = turn_b_q;
   assign bus.running    = running_q;
   assign bus.flag_w     = flag_w_q;
   assign bus.flag_b     = flag_b_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_chess_clock_timer.sv
// Directed bench for chess_clock_timer: two instances (5:00 +40 s, and 0:02) checked through an expected queue.
module tb_chess_clock_timer;

   localparam int W = 25;
   localparam logic [4:0] EV_START = 5'b10000;
   localparam logic [4:0] EV_PW    = 5'b01000;
   localparam logic [4:0] EV_PB    = 5'b00100;
   localparam logic [4:0] EV_PAUSE = 5'b00010;
   localparam logic [4:0] EV_NG    = 5'b00001;

   logic clk = 1'b0;
   logic rst_n;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           total = 0;
   int           bad   = 0;

   chess_clock_timer_if if_a ();
   chess_clock_timer_if if_b ();

   chess_clock_timer #(
      .CLK_HZ(10), .INIT_MIN(5), .INIT_SEC(0), .INC_SEC(40)
   ) dut_a (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (if_a)
   );

   chess_clock_timer #(
      .CLK_HZ(10), .INIT_MIN(0), .INIT_SEC(2), .INC_SEC(0)
   ) dut_b (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (if_b)
   );

   // clock / reset
   always #5 clk = ~clk;

   // driver tasks
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit which, input logic [4:0] v);
      if (!which) {if_a.start, if_a.press_w, if_a.press_b, if_a.pause, if_a.new_game} = v;
      else        {if_b.start, if_b.press_w, if_b.press_b, if_b.pause, if_b.new_game} = v;
   endtask

   task automatic pulse(input bit which, input logic [4:0] v);
      drive(which, v);
      step(1);
      drive(which, 5'b0);
   endtask

   // f = {turn_b, running, flag_w, flag_b}
   task automatic expect_st(input bit which, input string nm, input logic [9:0] w,
                            input logic [9:0] b, input logic [3:0] f);
      exp_q.push_back({which, w, b, f});
      name_q.push_back(nm);
   endtask

   // scoreboard monitor: compares on the falling edge, away from the active edge
   initial begin
      logic [W-1:0] e;
      logic [23:0]  act;
      string        nm;
      forever begin
         @(negedge clk);
         while (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (!e[24])
               act = {if_a.countdownW, if_a.countdownB, if_a.turn_b, if_a.running, if_a.flag_w, if_a.flag_b};
            else
               act = {if_b.countdownW, if_b.countdownB, if_b.turn_b, if_b.running, if_b.flag_w, if_b.flag_b};
            total++;
            if (act !== e[23:0]) begin
               bad++;
               $display("FAIL %s: got W=%h B=%h flags=%b, want W=%h B=%h flags=%b",
                        nm, act[23:14], act[13:4], act[3:0], e[23:14], e[13:4], e[3:0]);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      drive(0, 5'b0);
      drive(1, 5'b0);
      step(2);
      rst_n = 1'b1;
      step(1);
      expect_st(0, "reset_a", 10'h140, 10'h140, 4'b0000);
      expect_st(1, "reset_b", 10'h002, 10'h002, 4'b0000);

      // short bank: run white down to a flag
      pulse(1, EV_START);
      expect_st(1, "b_start", 10'h002, 10'h002, 4'b0100);
      step(10);
      expect_st(1, "b_tick1", 10'h001, 10'h002, 4'b0100);
      step(10);
      expect_st(1, "b_timeout", 10'h000, 10'h002, 4'b0010);
      pulse(1, EV_PW);
      pulse(1, EV_START);
      pulse(1, EV_PAUSE);
      step(12);
      expect_st(1, "b_frozen", 10'h000, 10'h002, 4'b0010);
      pulse(1, EV_NG);
      expect_st(1, "b_new_game", 10'h002, 10'h002, 4'b0000);
      pulse(1, EV_PW | EV_PAUSE);
      step(12);
      expect_st(1, "b_idle_hold", 10'h002, 10'h002, 4'b0000);
      pulse(1, EV_START | EV_NG);
      step(12);
      expect_st(1, "b_ng_beats_start", 10'h002, 10'h002, 4'b0000);

      // 5:00 bank with 40 s increment
      pulse(0, EV_START);
      expect_st(0, "a_start", 10'h140, 10'h140, 4'b0100);
      step(9);
      expect_st(0, "a_pre_tick", 10'h140, 10'h140, 4'b0100);
      step(1);
      expect_st(0, "a_first_tick", 10'h13B, 10'h140, 4'b0100);
      pulse(0, EV_PW);
      expect_st(0, "a_w_inc", 10'h167, 10'h140, 4'b1100);
      pulse(0, EV_PW);
      expect_st(0, "a_w_press_ignored", 10'h167, 10'h140, 4'b1100);
      pulse(0, EV_PB);
      expect_st(0, "a_b_inc", 10'h167, 10'h168, 4'b0100);
      step(10);
      expect_st(0, "a_w_tick", 10'h166, 10'h168, 4'b0100);
      pulse(0, EV_PW);
      expect_st(0, "a_w_saturate", 10'h17B, 10'h168, 4'b1100);
      pulse(0, EV_PW | EV_PB);
      expect_st(0, "a_both_press", 10'h17B, 10'h17B, 4'b0100);

      // pause four cycles into a second
      step(4);
      pulse(0, EV_PAUSE);
      expect_st(0, "a_paused", 10'h17B, 10'h17B, 4'b0000);
      step(100);
      pulse(0, EV_PW);
      expect_st(0, "a_pause_hold", 10'h17B, 10'h17B, 4'b0000);
      pulse(0, EV_PAUSE);
      expect_st(0, "a_resume", 10'h17B, 10'h17B, 4'b0100);
      step(5);
      expect_st(0, "a_resume_no_tick", 10'h17B, 10'h17B, 4'b0100);
      step(1);
      expect_st(0, "a_resume_tick", 10'h17A, 10'h17B, 4'b0100);

      pulse(0, EV_NG | EV_PW);
      expect_st(0, "a_new_game", 10'h140, 10'h140, 4'b0000);
      pulse(0, EV_START);
      pulse(0, EV_PW);
      expect_st(0, "a_run_b", 10'h168, 10'h140, 4'b1100);
      step(3);

      // asynchronous reset between clock edges
      rst_n = 1'b0;
      #1;
      expect_st(0, "a_async_reset", 10'h140, 10'h140, 4'b0000);
      expect_st(1, "b_async_reset", 10'h002, 10'h002, 4'b0000);
      step(2);

      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chess_clock_timer.md
Name: chess_clock_timer

Overview:
- Two-player countdown engine for the chess clock: one mm:ss time bank per player, a 1 Hz tick prescaler, and turn/pause/timeout control.
- Drives countdownW/countdownB straight into the number display decoder stage. Field layout: [9] = 0, [8:6] = minutes 0-5, [5:0] = seconds 0-59.
- Sits between the debounced button logic and the display decoder.

Parameters:
- CLK_HZ, 100_000_000: clk cycles per one-second tick. Must be at least 2.
- INIT_MIN, 5: minutes loaded at reset or new_game. Range 0-5.
- INIT_SEC, 0: seconds loaded at reset or new_game. Range 0-59. INIT_MIN:INIT_SEC must be non-zero.
- INC_SEC, 0: Fischer increment added to the mover's bank on a turn switch. Range 0-59.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  level, debounced; rising edge starts the game
- press_w  in  1  level, debounced; white ends turn
- press_b  in  1  level, debounced; black ends turn
- pause  in  1  level, debounced; rising edge toggles pause
- new_game  in  1  level; rising edge reloads the clock
- countdownW  out  10  white bank {1'b0, min[2:0], sec[5:0]}
- countdownB  out  10  black bank, same format
- turn_b  out  1  1 = black to move
- running  out  1  1 in RUN_W or RUN_B
- flag_w  out  1  white time expired
- flag_b  out  1  black time expired

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset: countdownW = countdownB = {0, INIT_MIN, INIT_SEC}; state IDLE; prescaler 0; turn_b, running, flag_w, flag_b = 0. All edge-detect registers clear to 0.
- All inputs are rising-edge detected internally. The event takes effect in the cycle after the edge; all outputs are registered.
- States: IDLE, RUN_W, RUN_B, PAUSED, TIMEOUT. PAUSED stores the side that was running.
- IDLE: start edge -> RUN_W, prescaler cleared. All other inputs are ignored except new_game.
- RUN_x prescaler: increments every cycle. At CLK_HZ-1 it wraps to 0 and issues a tick.
- RUN_x tick on the active bank:
  - sec > 0: sec - 1.
  - else min > 0: min - 1, sec = 59.
  - If the result is 0:00: state -> TIMEOUT, flag_x = 1, running = 0.
- RUN_W with press_w edge:
  - Add INC_SEC to the white bank; saturate at 5:59 with carry into minutes.
  - Go to RUN_B, clear the prescaler, set turn_b = 1.
  - RUN_B is symmetric.
- A press by the non-active player is ignored. Simultaneous press_w and press_b: only the active player's press counts.
- Tick and active press in the same cycle:
  - Apply the decrement first, then the increment.
  - If the decrement reaches 0:00, TIMEOUT wins and the press is ignored.
- pause edge in RUN_x -> PAUSED, prescaler held (not cleared). pause edge in PAUSED -> back to the stored side; the prescaler resumes from its held value.
- Presses are ignored while PAUSED.
- TIMEOUT: banks frozen; flags held. start, press, and pause are ignored.
- new_game edge from any state:
  - Reload both banks, prescaler 0, flags 0, turn_b 0; go to IDLE.
  - new_game beats every other simultaneous event.
- Asserting rst_n mid-run returns everything to reset values immediately, without waiting for clk.
- Bit 9 of both countdown outputs is constant 0. The minutes field never exceeds 5; the seconds field never exceeds 59.

Decomposition:
- Package chess_clock_pkg holds:
  - state enum
  - MAX_MIN = 5, MAX_SEC = 59
  - field constants MIN_MSB = 8, MIN_LSB = 6, SEC_MSB = 5
- Sub-module mmss_bank, instantiated twice:
  - inputs: load, dec, inc_en, inc value
  - behaviour: saturating add, borrow on decrement, zero flag
- The prescaler and FSM stay in the top level.

Test Plan:
- Reset, CLK_HZ=10 -> countdownW = countdownB = 10'h140; turn_b = 0, running = 0.
- start edge, wait 10 cycles -> countdownW = 10'h13B (4:59); countdownB still 10'h140; running = 1.
- INC_SEC=40: white presses at 4:59 -> W = 5:39 (10'h167) and turn_b = 1. Black presses. White presses again at 5:38 -> W saturates to 5:59 (10'h17B).
- INIT 0:02: start, then 20 cycles -> W = 10'h000, flag_w = 1, running = 0. press_w, start, and pause are ignored. new_game -> both banks 10'h002, IDLE.
- Pause after 4 cycles into a second, hold 100 cycles, unpause -> next tick exactly 6 cycles later; the bank is unchanged during the pause.
- rst_n low mid-RUN_B, between clk edges -> outputs return to reset values before the next clk edge.
